mips_fetch: RTL

//  Instruction-fetch stage feeding mips_cpu decode. Holds the PC, issues Avalon-MM reads for instruction words,

---
 rtl/mips_pkg.sv | 24 ++
 rtl/mips_fetch.sv | 122 ++++++++++++
 2 files changed

// File: rtl/mips_pkg.sv
// Shared definitions for the MIPS fetch stage: reset/halt addresses, fetch FSM states, byte swap.
package mips_pkg;

   localparam int unsigned XLEN = 32;

   // Default PC after reset and the jump target that halts the CPU
   localparam logic [XLEN-1:0] DEF_RESET_VECTOR = 32'hBFC0_0000;
   localparam logic [XLEN-1:0] DEF_HALT_ADDR    = 32'h0000_0000;

   // Clears the byte-offset bits of a word address
   localparam logic [XLEN-1:0] WORD_MASK = 32'hFFFF_FFFC;

   typedef enum logic [1:0] {
      FETCH  = 2'd0,
      HOLD   = 2'd1,
      HALTED = 2'd2
   } fetch_state_t;

   // Reverse byte order: little-endian bus word -> big-endian instruction word
   function automatic logic [XLEN-1:0] bswap32(input logic [XLEN-1:0] w);
      return {w[7:0], w[15:8], w[23:16], w[31:24]};
   endfunction

endpackage

// File: rtl/mips_fetch.sv
// Instruction fetch stage: one Avalon-MM read at a time, hands each word to decode,
// applies taken branches/jumps after the delay slot, and halts on a jump to HALT_ADDR.
module mips_fetch
   import mips_pkg::*;
#(
   parameter logic [XLEN-1:0] RESET_VECTOR = DEF_RESET_VECTOR,
   parameter logic [XLEN-1:0] HALT_ADDR    = DEF_HALT_ADDR,
   parameter bit              BYTE_SWAP    = 1'b1
) (
   input  logic            clk,
   input  logic            reset,
   output logic            active,
   output logic [XLEN-1:0] address,
   output logic            read,
   input  logic            waitrequest,
   input  logic [XLEN-1:0] readdata,
   output logic [XLEN-1:0] instr,
   output logic [XLEN-1:0] instr_pc,
   output logic            instr_valid,
   input  logic            instr_ready,
   input  logic            redirect_valid,
   input  logic [XLEN-1:0] redirect_target
);

   fetch_state_t    state_q;
   logic [XLEN-1:0] pc_q;
   logic [XLEN-1:0] tgt_q;
   logic            pending_q;
   logic [XLEN-1:0] instr_q;
   logic [XLEN-1:0] instr_pc_q;
   logic            instr_valid_q;
   logic            active_q;

   logic [XLEN-1:0] pc_inc_d;
   logic [XLEN-1:0] fetch_word_d;
   logic [XLEN-1:0] redirect_aligned_d;
   logic            consume_d;
   logic            halt_hit_d;

   // Datapath helpers: sequential PC, bus word in instruction byte order, aligned redirect
   always_comb begin
      pc_inc_d           = pc_q + XLEN'(4);
      fetch_word_d       = BYTE_SWAP ? bswap32(readdata) : readdata;
      redirect_aligned_d = redirect_target & WORD_MASK;
      consume_d          = instr_valid_q && instr_ready;
      halt_hit_d         = (tgt_q == (HALT_ADDR & WORD_MASK));
   end

   // Fetch FSM with PC, delay-slot redirect bookkeeping and the instruction holding register
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q       <= FETCH;
         pc_q          <= RESET_VECTOR & WORD_MASK;
         tgt_q         <= '0;
         pending_q     <= 1'b0;
         instr_q       <= '0;
         instr_pc_q    <= '0;
         instr_valid_q <= 1'b0;
         active_q      <= 1'b0;
      end else begin
         case (state_q)
            FETCH: begin
               // active_q is still low on the first edge after reset, so no read is in flight yet
               active_q <= 1'b1;
               if (active_q && !waitrequest) begin
                  instr_q       <= fetch_word_d;
                  instr_pc_q    <= pc_q;
                  instr_valid_q <= 1'b1;
                  state_q       <= HOLD;
               end
            end
            HOLD: begin
               if (consume_d) begin
                  instr_valid_q <= 1'b0;
                  if (pending_q) begin
                     // Delay slot retired: redirect now; a jump sitting in the delay slot is dropped
                     pending_q <= 1'b0;
                     if (halt_hit_d) begin
                        state_q  <= HALTED;
                        active_q <= 1'b0;
                     end else begin
                        pc_q    <= tgt_q;
                        state_q <= FETCH;
                     end
                  end else if (redirect_valid) begin
                     tgt_q     <= redirect_aligned_d;
                     pending_q <= 1'b1;
                     pc_q      <= pc_inc_d;
                     state_q   <= FETCH;
                  end else begin
                     pc_q    <= pc_inc_d;
                     state_q <= FETCH;
                  end
               end
            end
            HALTED: begin
               active_q      <= 1'b0;
               instr_valid_q <= 1'b0;
            end
            default: begin
               state_q       <= HALTED;
               active_q      <= 1'b0;
               instr_valid_q <= 1'b0;
            end
         endcase
      end
   end

   // Bus strobe/address and CPU status decoded from the registered state
   always_comb begin
      read        = 1'b0;
      address     = pc_q & WORD_MASK;
      active      = active_q;
      instr       = instr_q;
      instr_pc    = instr_pc_q;
      instr_valid = instr_valid_q;
      if (active_q && (state_q == FETCH)) begin
         read = 1'b1;
      end
   end

endmodule
